// File: rtl/upper_stream_buf.sv
// rtl/upper_stream_buf.sv - ASCII upper-case conversion stage with DEPTH-entry output FIFO
module upper_stream_buf #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_char,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_char,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         char_cnt,
   output logic [CNT_W-1:0]         conv_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic             is_lower;
   logic [7:0]       conv_char;

   assign in_ready  = (level != LVL_W'(DEPTH));
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Lower-case letters differ from upper-case only in bit 5.
   assign is_lower  = (in_char >= 8'h61) && (in_char <= 8'h7A);
   assign conv_char = is_lower ? {in_char[7:6], 1'b0, in_char[4:0]} : in_char;

   assign out_char  = out_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= conv_char;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_cnt <= '0;
         conv_cnt <= '0;
      end else if (push) begin
         if (char_cnt != '1) begin
            char_cnt <= char_cnt + 1'b1;
         end
         if (is_lower && (conv_cnt != '1)) begin
            conv_cnt <= conv_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_upper_stream_buf.sv
// tb/tb_upper_stream_buf.sv - self-checking bench for upper_stream_buf against a queue model
module tb_upper_stream_buf;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_char = 8'h00;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [7:0]       out_char;
   logic [2:0]       level;
   logic [CNT_W-1:0] char_cnt;
   logic [CNT_W-1:0] conv_cnt;

   int n_tests = 0;
   int n_fail = 0;

   logic [7:0] mq[$];
   int         m_char = 0;
   int         m_conv = 0;
   int         n_model_pops = 0;
   int         n_dut_pops = 0;
   logic [7:0] dut_pops[$];

   upper_stream_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_char   (in_char),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .level     (level),
      .char_cnt  (char_cnt),
      .conv_cnt  (conv_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] upcase(input logic [7:0] c);
      if (c >= "a" && c <= "z") return c - 8'd32;
      return c;
   endfunction

   // Reference model: a plain queue with the conversion applied on entry.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_char = 0;
         m_conv = 0;
      end else begin
         bit do_push;
         bit do_pop;
         do_push = in_valid && (mq.size() < DEPTH);
         do_pop  = out_ready && (mq.size() > 0);
         if (do_pop) begin
            void'(mq.pop_front());
            n_model_pops++;
         end
         if (do_push) begin
            mq.push_back(upcase(in_char));
            if (m_char < CNT_MAX) m_char++;
            if (upcase(in_char) != in_char && m_conv < CNT_MAX) m_conv++;
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         dut_pops.push_back(out_char);
         n_dut_pops++;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cmp_out_valid", 32'(out_valid), 32'(mq.size() != 0));
         check("cmp_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
         check("cmp_level", 32'(level), 32'(mq.size()));
         if (mq.size() != 0) check("cmp_out_char", 32'(out_char), 32'(mq[0]));
         check("cmp_char_cnt", 32'(char_cnt), 32'(m_char));
         check("cmp_conv_cnt", 32'(conv_cnt), 32'(m_conv));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] t2_in  [6];
      logic [7:0] t2_exp [6];
      int         guard;
      t2_in  = '{8'h60, 8'h61, 8'h7A, 8'h7B, 8'h41, 8'hE1};
      t2_exp = '{8'h60, 8'h41, 8'h5A, 8'h7B, 8'h41, 8'hE1};

      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_level", 32'(level), 32'd0);
      check("rst_out_char", 32'(out_char), 32'h00);
      check("rst_char_cnt", 32'(char_cnt), 32'd0);
      check("rst_conv_cnt", 32'(conv_cnt), 32'd0);
      step();
      rst_n = 1'b1;

      // 1: single push of 'h'
      in_valid = 1'b1; in_char = 8'h68; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_char", 32'(out_char), 32'h48);
      check("t1_level", 32'(level), 32'd1);
      check("t1_char_cnt", 32'(char_cnt), 32'd1);
      check("t1_conv_cnt", 32'(conv_cnt), 32'd1);
      out_ready = 1'b1;
      step();

      // 2: conversion boundaries back-to-back
      pulse_reset();
      dut_pops.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_char = t2_in[i];
         step();
      end
      in_valid = 1'b0;
      step(3);
      check("t2_pop_count", 32'(dut_pops.size()), 32'd6);
      for (int i = 0; i < 6 && i < dut_pops.size(); i++)
         check($sformatf("t2_pop%0d", i), 32'(dut_pops[i]), 32'(t2_exp[i]));
      check("t2_conv_cnt", 32'(conv_cnt), 32'd2);
      check("t2_char_cnt", 32'(char_cnt), 32'd6);

      // 3: fill, ignored fifth push
      pulse_reset();
      dut_pops.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_char = 8'h61 + 8'(i);
         step();
      end
      check("t3_level_full", 32'(level), 32'd4);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      in_char = "e";
      step();
      check("t3_char_cnt", 32'(char_cnt), 32'd4);
      check("t3_level_hold", 32'(level), 32'd4);
      check("t3_head", 32'(out_char), 32'h41);

      // 5: full with push+pop request, then push+pop at level 3
      out_ready = 1'b1;
      step();
      check("t5_level_pop_only", 32'(level), 32'd3);
      check("t5_char_cnt", 32'(char_cnt), 32'd4);
      step();
      check("t5_level_both", 32'(level), 32'd3);
      check("t5_char_cnt2", 32'(char_cnt), 32'd5);
      check("t5_pop_count", 32'(dut_pops.size()), 32'd2);
      if (dut_pops.size() >= 2) begin
         check("t5_pop0", 32'(dut_pops[0]), 32'h41);
         check("t5_pop1", 32'(dut_pops[1]), 32'h42);
      end
      check("t5_head", 32'(out_char), 32'h43);

      // 6: asynchronous reset mid-stream at level 3
      in_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_level", 32'(level), 32'd0);
      check("t6_char_cnt", 32'(char_cnt), 32'd0);
      check("t6_conv_cnt", 32'(conv_cnt), 32'd0);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      check("t6_out_char", 32'(out_char), 32'h00);
      step();
      rst_n = 1'b1;
      in_valid = 1'b1; in_char = 8'h7A;
      step();
      in_valid = 1'b0;
      check("t6_first_char", 32'(out_char), 32'h5A);
      check("t6_first_valid", 32'(out_valid), 32'd1);

      // 4: random traffic against the model
      n_model_pops = 0;
      n_dut_pops = 0;
      for (int i = 0; i < 2000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) in_char = 8'($urandom_range(0, 255));
         else in_char = 8'($urandom_range(8'h5F, 8'h7D));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      guard = 0;
      while (level != 0 && guard < 20) begin
         step();
         guard++;
      end
      check("t4_drained", 32'(level), 32'd0);
      check("t4_pop_match", 32'(n_dut_pops), 32'(n_model_pops));
      check("t4_char_sat", 32'(char_cnt), 32'(CNT_MAX));
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
